csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit_pkg.sv | 45 ++++
 rtl/csr_alu.sv | 43 ++++
 rtl/csr_unit.sv | 129 ++++++++++++
 tb/tb_csr_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_unit_pkg.sv
// Shared definitions for the CSR execution unit.
// Holds CSR addresses, the "no access" address, funct3 op codes and FSM states.
// Pure declarations; no logic or timing of its own.
package csr_unit_pkg;

  // CSR addresses implemented by this core
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;

  // Address driven on raddr/waddr when no access is intended
  localparam logic [11:0] CSR_ADDR_DISABLE = 12'hFFF;

  // funct3 encodings of the Zicsr instructions
  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WCSR = 2'd2,
    ST_WRD  = 2'd3
  } state_t;

  // True for every CSR address this core implements
  function automatic logic csr_addr_known(input logic [11:0] addr);
    logic known;
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCYCLE, CSR_MCYCLEH, CSR_MVENDORID: known = 1'b1;
      default:                                           known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// New-value and legality computation for one CSR instruction.
// Purely combinational, zero latency.
// No flow control; results are qualified by the caller's FSM state.
module csr_alu
  import csr_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [11:0] csr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] operand,
  input  logic [31:0] old_val,
  output logic [31:0] new_val,
  output logic        wr_req,
  output logic        illegal
);

  logic op_valid;

  // Select the write value; set/clear forms with rs1/zimm = 0 are read-only
  always_comb begin
    new_val  = 32'd0;
    wr_req   = 1'b0;
    op_valid = 1'b1;
    case (op)
      OP_RW, OP_RWI: begin
        new_val = operand;
        wr_req  = 1'b1;
      end
      OP_RS, OP_RSI: begin
        new_val = old_val | operand;
        wr_req  = (rs1_idx != 5'd0);
      end
      OP_RC, OP_RCI: begin
        new_val = old_val & ~operand;
        wr_req  = (rs1_idx != 5'd0);
      end
      default: op_valid = 1'b0;
    endcase
    // Unknown address, or a real write to the read-only space [11:10]=11
    illegal = !op_valid || !csr_addr_known(csr) || (wr_req && (csr[11:10] == 2'b11));
  end

endmodule

// File: rtl/csr_unit.sv
// Executes one CSR instruction: read, CSR write, rd write, then ready again.
// Fixed latency: accept T, CSR write T+2, rd write and resp_valid T+3.
// req_ready only in IDLE; flush aborts in READ, is ignored once writing starts.
module csr_unit
  import csr_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        rd_we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_illegal
);

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [11:0] csr_q;
  logic [31:0] operand_q;
  logic [4:0]  rs1_idx_q;
  logic [4:0]  rd_q;
  logic [31:0] old_q;
  logic [31:0] new_val;
  logic        wr_req;
  logic        illegal;
  logic        accept;

  // A flush in IDLE blocks acceptance for that cycle
  assign accept = !rst && (state == ST_IDLE) && req_valid && !flush;

  csr_alu u_alu (
    .op      (op_q),
    .csr     (csr_q),
    .rs1_idx (rs1_idx_q),
    .operand (operand_q),
    .old_val (old_q),
    .new_val (new_val),
    .wr_req  (wr_req),
    .illegal (illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Latch the instruction on accept and the old CSR value during READ
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 3'd0;
      csr_q     <= CSR_ADDR_DISABLE;
      operand_q <= 32'd0;
      rs1_idx_q <= 5'd0;
      rd_q      <= 5'd0;
      old_q     <= 32'd0;
    end else begin
      if (accept) begin
        op_q      <= req_op;
        csr_q     <= req_csr;
        operand_q <= req_op[2] ? {27'd0, req_rs1_idx} : req_rs1_data;
        rs1_idx_q <= req_rs1_idx;
        rd_q      <= req_rd;
      end
      if (state == ST_READ) old_q <= csr_rdata;
    end
  end

  // Next state and per-state outputs; reset forces idle outputs so an
  // in-flight write is never presented while rst is high
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    csr_raddr    = CSR_ADDR_DISABLE;
    csr_waddr    = CSR_ADDR_DISABLE;
    csr_wdata    = 32'd0;
    rd_we        = 1'b0;
    waddr        = 5'd0;
    wdata        = 32'd0;
    resp_valid   = 1'b0;
    resp_illegal = 1'b0;
    if (rst) begin
      state_nxt = ST_IDLE;
      req_ready = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (accept) state_nxt = ST_READ;
        end
        ST_READ: begin
          csr_raddr = csr_q;
          state_nxt = flush ? ST_IDLE : ST_WCSR;
        end
        ST_WCSR: begin
          if (!illegal && wr_req) begin
            csr_waddr = csr_q;
            csr_wdata = new_val;
          end
          state_nxt = ST_WRD;
        end
        ST_WRD: begin
          resp_valid   = 1'b1;
          resp_illegal = illegal;
          if (!illegal && (rd_q != 5'd0)) begin
            rd_we = 1'b1;
            waddr = rd_q;
            wdata = old_q;
          end
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: expected reads, CSR writes and responses
// are queued at accept time and compared as the DUT produces them.
module tb_csr_unit;
  import csr_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd;
  logic        flush;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        rd_we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_illegal;

  csr_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_csr      (req_csr),
    .req_rs1_idx  (req_rs1_idx),
    .req_rs1_data (req_rs1_data),
    .req_rd       (req_rd),
    .flush        (flush),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .rd_we        (rd_we),
    .waddr        (waddr),
    .wdata        (wdata),
    .resp_valid   (resp_valid),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  // Combinational CSR file seen by the DUT
  logic [31:0] csr_mem [0:4095];
  assign csr_rdata = csr_mem[csr_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic [11:0] a; }                 rd_exp_t;
  typedef struct { int t; logic [11:0] a; logic [31:0] d; } cw_exp_t;
  typedef struct { int t; logic ill; logic we; logic [4:0] a; logic [31:0] d; } rsp_exp_t;

  rd_exp_t  rq[$];
  cw_exp_t  cq[$];
  rsp_exp_t pq[$];
  rd_exp_t  r_e;
  cw_exp_t  c_e;
  rsp_exp_t p_e;

  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: queue everything this instruction should produce
  task automatic model_push(input logic [2:0] op, input logic [11:0] csr, input logic [4:0] rs1,
                            input logic [31:0] data, input logic [4:0] rd, input logic [31:0] old,
                            input int t, input bit commit);
    logic [31:0] opnd, nv;
    logic        legal, opv, wr, ill;
    rq.push_back('{t: t + 1, a: csr});
    if (!commit) return;
    opnd  = op[2] ? {27'd0, rs1} : data;
    opv   = (op != 3'b000) && (op != 3'b100);
    wr    = (op[1:0] == 2'b01) || (rs1 != 5'd0);
    legal = (csr == 12'h300) || (csr == 12'h301) || (csr == 12'h305) || (csr == 12'h340) ||
            (csr == 12'h341) || (csr == 12'hB00) || (csr == 12'hB80) || (csr == 12'hF11);
    ill   = !opv || !legal || (wr && (csr[11:10] == 2'b11));
    case (op[1:0])
      2'b01:   nv = opnd;
      2'b10:   nv = old | opnd;
      default: nv = old & ~opnd;
    endcase
    if (!ill && wr) cq.push_back('{t: t + 2, a: csr, d: nv});
    if (!ill && rd != 5'd0) pq.push_back('{t: t + 3, ill: 1'b0, we: 1'b1, a: rd, d: old});
    else                    pq.push_back('{t: t + 3, ill: ill, we: 1'b0, a: 5'd0, d: 32'd0});
  endtask

  // Drive one instruction from a negedge; returns on the negedge after accept
  task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [4:0] rs1,
                       input logic [31:0] data, input logic [4:0] rd, input logic [31:0] old,
                       input bit commit, input bit keep_valid, output int t);
    bit ok = 1'b0;
    t = -1;
    csr_mem[csr] = old;
    req_valid = 1'b1; req_op = op; req_csr = csr;
    req_rs1_idx = rs1; req_rs1_data = data; req_rd = rd;
    for (int i = 0; i < 20 && !ok; i++) begin
      #2;
      if (req_ready && !flush && !rst) begin
        ok = 1'b1;
        t  = cyc;
        model_push(op, csr, rs1, data, rd, old, t, commit);
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (!keep_valid) req_valid = 1'b0;
  endtask

  // Output monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (csr_raddr != CSR_ADDR_DISABLE) begin
        if (rq.size() == 0) check("raddr_unexpected", {20'd0, csr_raddr}, {20'd0, CSR_ADDR_DISABLE});
        else begin
          r_e = rq.pop_front();
          check("raddr", {20'd0, csr_raddr}, {20'd0, r_e.a});
          check("raddr_cycle", cyc, r_e.t);
        end
      end
      if (csr_waddr != CSR_ADDR_DISABLE) begin
        check("csr_rd_overlap", {31'd0, rd_we}, 32'd0);
        if (cq.size() == 0) check("csr_wr_unexpected", {20'd0, csr_waddr}, {20'd0, CSR_ADDR_DISABLE});
        else begin
          c_e = cq.pop_front();
          check("csr_waddr", {20'd0, csr_waddr}, {20'd0, c_e.a});
          check("csr_wdata", csr_wdata, c_e.d);
          check("csr_wr_cycle", cyc, c_e.t);
        end
      end else check("csr_wdata_idle", csr_wdata, 32'd0);
      if (resp_valid) begin
        if (pq.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else begin
          p_e = pq.pop_front();
          check("resp_cycle", cyc, p_e.t);
          check("resp_illegal", {31'd0, resp_illegal}, {31'd0, p_e.ill});
          check("rd_we", {31'd0, rd_we}, {31'd0, p_e.we});
          check("rd_waddr", {27'd0, waddr}, {27'd0, p_e.a});
          check("rd_wdata", wdata, p_e.d);
        end
      end else begin
        check("rd_idle", {25'd0, resp_illegal, rd_we, waddr}, 32'd0);
        check("rd_wdata_idle", wdata, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end

  int t0, t1, t2;

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'hC500_0000 | 32'(i);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    req_op = 3'd0; req_csr = 12'd0; req_rs1_idx = 5'd0; req_rs1_data = 32'd0; req_rd = 5'd0;
    repeat (3) @(negedge clk);
    // Reset-state outputs
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_raddr", {20'd0, csr_raddr}, {20'd0, CSR_ADDR_DISABLE});
    check("rst_waddr", {20'd0, csr_waddr}, {20'd0, CSR_ADDR_DISABLE});
    check("rst_misc", {csr_wdata[31:8], csr_wdata[7:0] | wdata[7:0]}, 32'd0);
    check("rst_flags", {24'd0, rd_we, resp_valid, resp_illegal, waddr}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // CSRRW x5, mscratch
    issue(OP_RW, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 32'h12345678, 1, 0, t0);
    repeat (3) @(negedge clk);
    // CSRRS x0, mstatus, x0: pure no-op read
    issue(OP_RS, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0000_1888, 1, 0, t0);
    repeat (3) @(negedge clk);
    // CSRRCI x9, mepc, 3
    issue(OP_RCI, 12'h341, 5'd3, 32'hFFFF_FFFF, 5'd9, 32'h0000_00FF, 1, 0, t0);
    repeat (3) @(negedge clk);
    // CSRRW to mvendorid: illegal write to read-only space
    issue(OP_RW, 12'hF11, 5'd3, 32'h1111_2222, 5'd4, 32'h0000_0ABC, 1, 0, t0);
    repeat (3) @(negedge clk);
    // CSRRS x6, mvendorid, x0: legal read
    issue(OP_RS, 12'hF11, 5'd0, 32'h1111_2222, 5'd6, 32'h0000_0ABC, 1, 0, t0);
    repeat (3) @(negedge clk);
    // Unknown address
    issue(OP_RS, 12'h123, 5'd7, 32'h0000_00F0, 5'd8, 32'h5555_AAAA, 1, 0, t0);
    repeat (3) @(negedge clk);
    // CSRRSI mtvec, zimm 0: read only
    issue(OP_RSI, 12'h305, 5'd0, 32'hFFFF_FFFF, 5'd10, 32'h8000_0100, 1, 0, t0);
    repeat (3) @(negedge clk);
    // CSRRC mstatus with register operand
    issue(OP_RC, 12'h300, 5'd2, 32'h0000_F0F0, 5'd11, 32'hFFFF_00FF, 1, 0, t0);
    repeat (3) @(negedge clk);
    // CSRRWI mcycle, 31
    issue(OP_RWI, 12'hB00, 5'd31, 32'hFFFF_FFFF, 5'd12, 32'h0BAD_F00D, 1, 0, t0);
    repeat (3) @(negedge clk);

    // Flush during READ: aborted, ready next cycle
    issue(OP_RW, 12'h340, 5'd1, 32'hCAFE_0001, 5'd13, 32'h7777_7777, 0, 0, t0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_read_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Flush across WCSR and WRD: ignored
    issue(OP_RS, 12'h301, 5'd4, 32'h0000_0010, 5'd14, 32'h4000_0100, 1, 0, t0);
    @(negedge clk);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; req_op = OP_RW; req_csr = 12'h341; req_rs1_idx = 5'd1;
    req_rs1_data = 32'h1; req_rd = 5'd1; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_no_read", {20'd0, csr_raddr}, {20'd0, CSR_ADDR_DISABLE});
    flush = 1'b0;
    issue(OP_RW, 12'h341, 5'd1, 32'h0000_2000, 5'd1, 32'h0000_3000, 1, 0, t0);
    repeat (3) @(negedge clk);

    // Reset during WCSR: the pending write is dropped
    issue(OP_RW, 12'h340, 5'd1, 32'h9999_9999, 5'd15, 32'h6666_6666, 0, 0, t0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wcsr_waddr", {20'd0, csr_waddr}, {20'd0, CSR_ADDR_DISABLE});
    check("rst_wcsr_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    // Back-to-back with req_valid held high
    issue(OP_RW, 12'hB80, 5'd3, 32'h0000_0042, 5'd16, 32'h0000_0001, 1, 1, t0);
    issue(OP_RS, 12'h301, 5'd5, 32'h0000_0003, 5'd17, 32'h4000_0000, 1, 1, t1);
    issue(OP_RC, 12'h340, 5'd6, 32'h0000_000F, 5'd18, 32'hFFFF_FFFF, 1, 0, t2);
    check("b2b_gap_1", t1 - t0, 32'd4);
    check("b2b_gap_2", t2 - t1, 32'd4);
    repeat (6) @(negedge clk);

    check("raddr_queue_drained", rq.size(), 32'd0);
    check("csr_wr_queue_drained", cq.size(), 32'd0);
    check("resp_queue_drained", pq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
